pipe_scoreboard: RTL and testbench

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

---
 rtl/pipe_scoreboard_if.sv | 31 +++
 rtl/pipe_scoreboard.sv | 92 +++++++++
 tb/tb_pipe_scoreboard.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_scoreboard_if.sv
// ID-stage hazard scoreboard handshake: decoded instruction in, issue/stall decision out.
interface pipe_scoreboard_if #(
    parameter int REG_W = 5
);
    logic             D_valid;
    logic [1:0]       D_kind;
    logic             D_use_rs1;
    logic             D_use_rs2;
    logic [REG_W-1:0] D_rs1_index;
    logic [REG_W-1:0] D_rs2_index;
    logic [REG_W-1:0] D_rd_index;
    logic             D_wr_rd;
    logic             flush;
    logic             D_issue;
    logic             stall;
    logic [1:0]       stall_cause;
    logic             md_busy;
    logic [31:0]      stall_cycles;

    modport master (
        output D_valid, D_kind, D_use_rs1, D_use_rs2, D_rs1_index, D_rs2_index,
               D_rd_index, D_wr_rd, flush,
        input  D_issue, stall, stall_cause, md_busy, stall_cycles
    );

    modport slave (
        input  D_valid, D_kind, D_use_rs1, D_use_rs2, D_rs1_index, D_rs2_index,
               D_rd_index, D_wr_rd, flush,
        output D_issue, stall, stall_cause, md_busy, stall_cycles
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// Per-register result-ready countdowns plus a mul/div occupancy counter; decides
// RAW/WAW/structural stalls for the ID-stage instruction in the same cycle.
module pipe_scoreboard #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 4
) (
    input  logic           clk,
    input  logic           rst,
    pipe_scoreboard_if.slave sb
);
    localparam int CNT_W = $clog2(MD_LAT + 1);
    localparam int NREG  = 2 ** REG_W;

    localparam logic [1:0] K_LOAD = 2'b01;
    localparam logic [1:0] K_MD   = 2'b10;

    localparam logic [1:0] C_NONE   = 2'b00;
    localparam logic [1:0] C_RAW    = 2'b01;
    localparam logic [1:0] C_WAW    = 2'b10;
    localparam logic [1:0] C_STRUCT = 2'b11;

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]           md_cnt;
    logic [CNT_W-1:0]           lat;
    logic [31:0]                stall_cycles_q;
    logic                       raw, waw, strct, stall_c, issue;
    logic [1:0]                 cause;

    always_comb begin
        case (sb.D_kind)
            K_LOAD:  lat = CNT_W'(LOAD_LAT);
            K_MD:    lat = CNT_W'(MD_LAT);
            default: lat = '0;
        endcase
    end

    // cnt[0] is cleared on reset and never loaded, so reading x0 never hazards.
    assign raw   = sb.D_valid & ((sb.D_use_rs1 & (cnt[sb.D_rs1_index] != '0)) |
                                 (sb.D_use_rs2 & (cnt[sb.D_rs2_index] != '0)));
    assign waw   = sb.D_valid & sb.D_wr_rd & (sb.D_rd_index != '0) &
                   (cnt[sb.D_rd_index] > lat);
    assign strct = sb.D_valid & (sb.D_kind == K_MD) & (md_cnt != '0);

    assign stall_c = ~rst & ~sb.flush & (raw | waw | strct);
    assign issue   = ~rst & sb.D_valid & ~sb.flush & ~stall_c;

    always_comb begin
        cause = C_NONE;
        if (stall_c) begin
            if (raw)      cause = C_RAW;
            else if (waw) cause = C_WAW;
            else          cause = C_STRUCT;
        end
    end

    // An issuing producer's reload takes precedence over the free-running decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (issue && sb.D_wr_rd && (sb.D_rd_index == REG_W'(r)) && (lat != '0))
                    cnt[r] <= lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            md_cnt <= '0;
        else if (issue && (sb.D_kind == K_MD))
            md_cnt <= CNT_W'(MD_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles_q <= '0;
        else if (stall_c)
            stall_cycles_q <= stall_cycles_q + 32'd1;
    end

    assign sb.D_issue      = issue;
    assign sb.stall        = stall_c;
    assign sb.stall_cause  = cause;
    assign sb.md_busy      = (md_cnt != '0);
    assign sb.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard with default latencies (LOAD_LAT=1, MD_LAT=4).
module tb_pipe_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_scoreboard_if #(.REG_W(5)) sb_if ();

    pipe_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    localparam logic [1:0] ALU = 2'b00, LD = 2'b01, MD = 2'b10;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [1:0] k, input logic u1, input logic u2,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic wr, input logic fl);
        sb_if.D_valid     = v;
        sb_if.D_kind      = k;
        sb_if.D_use_rs1   = u1;
        sb_if.D_use_rs2   = u2;
        sb_if.D_rs1_index = r1;
        sb_if.D_rs2_index = r2;
        sb_if.D_rd_index  = rd;
        sb_if.D_wr_rd     = wr;
        sb_if.flush       = fl;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, ALU, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stall(input string tag, input logic s, input logic [1:0] c, input logic iss);
        chk({tag, "_stall"}, {31'd0, sb_if.stall}, {31'd0, s});
        chk({tag, "_cause"}, {30'd0, sb_if.stall_cause}, {30'd0, c});
        chk({tag, "_issue"}, {31'd0, sb_if.D_issue}, {31'd0, iss});
    endtask

    initial begin
        // Reset: a pending hazard-free instruction must still see issue=0.
        drv(1'b1, MD, 1'b1, 1'b0, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0);
        chk_stall("rst", 1'b0, 2'b00, 1'b0);
        chk("rst_md_busy", {31'd0, sb_if.md_busy}, 32'd0);
        chk("rst_cycles", sb_if.stall_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        tick();

        // Load x5 then ALU reading x5: one RAW bubble.
        drv(1'b1, LD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
        chk("ld_issue", {31'd0, sb_if.D_issue}, 32'd1);
        tick();
        drv(1'b1, ALU, 1'b1, 1'b0, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
        chk_stall("raw1", 1'b1, 2'b01, 1'b0);
        tick();
        chk_stall("raw2", 1'b0, 2'b00, 1'b1);
        tick();
        idle();
        chk("cyc_a", sb_if.stall_cycles, 32'd1);

        // Mul x7 then independent mul: four structural stalls.
        drv(1'b1, MD, 1'b1, 1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
        chk("md1_issue", {31'd0, sb_if.D_issue}, 32'd1);
        tick();
        drv(1'b1, MD, 1'b1, 1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_stall("st", 1'b1, 2'b11, 1'b0);
            chk("st_busy", {31'd0, sb_if.md_busy}, 32'd1);
            tick();
        end
        chk_stall("st_end", 1'b0, 2'b00, 1'b1);
        chk("st_busy_end", {31'd0, sb_if.md_busy}, 32'd0);
        tick();
        idle();
        repeat (5) tick();
        chk("cyc_b", sb_if.stall_cycles, 32'd5);

        // Mul x3 then ALU overwriting x3 with no sources: WAW until cnt[3] drains.
        drv(1'b1, MD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        tick();
        drv(1'b1, ALU, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_stall("waw", 1'b1, 2'b10, 1'b0);
            tick();
        end
        chk_stall("waw_end", 1'b0, 2'b00, 1'b1);
        tick();
        idle();
        repeat (5) tick();
        chk("cyc_c", sb_if.stall_cycles, 32'd9);

        // Load to x0 never creates a hazard.
        drv(1'b1, LD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        drv(1'b1, ALU, 1'b1, 1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
        chk_stall("x0", 1'b0, 2'b00, 1'b1);
        tick();
        idle();
        chk("cyc_d", sb_if.stall_cycles, 32'd9);

        // Flush during a RAW stall, then the remaining count still stalls.
        drv(1'b1, MD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0);
        tick();
        drv(1'b1, ALU, 1'b1, 1'b0, 5'd10, 5'd0, 5'd11, 1'b1, 1'b1);
        chk_stall("fl", 1'b0, 2'b00, 1'b0);
        tick();
        drv(1'b1, ALU, 1'b1, 1'b0, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_stall("fl_raw", 1'b1, 2'b01, 1'b0);
            tick();
        end
        chk_stall("fl_end", 1'b0, 2'b00, 1'b1);
        tick();
        idle();
        repeat (5) tick();
        chk("cyc_e", sb_if.stall_cycles, 32'd12);

        // Source equal to own rd checks the pre-issue count only.
        drv(1'b1, LD, 1'b1, 1'b0, 5'd15, 5'd0, 5'd15, 1'b1, 1'b0);
        chk_stall("self", 1'b0, 2'b00, 1'b1);
        tick();
        idle();
        tick();

        // Reset mid-stall releases immediately; counters restart from zero.
        drv(1'b1, MD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0);
        tick();
        drv(1'b1, ALU, 1'b1, 1'b0, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0);
        chk_stall("pre_rst", 1'b1, 2'b01, 1'b0);
        rst = 1'b1;
        #1;
        chk_stall("mid_rst", 1'b0, 2'b00, 1'b0);
        chk("mid_rst_cyc", sb_if.stall_cycles, 32'd0);
        chk("mid_rst_busy", {31'd0, sb_if.md_busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk_stall("post_rst", 1'b0, 2'b00, 1'b1);
        tick();
        idle();
        tick();

        // Counter wrap: preset to all-ones, two structural stalls land on 1.
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        #1;
        chk("preset", sb_if.stall_cycles, 32'hFFFF_FFFF);
        drv(1'b1, MD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd20, 1'b1, 1'b0);
        tick();
        drv(1'b1, MD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd21, 1'b1, 1'b0);
        chk_stall("wrap_st", 1'b1, 2'b11, 1'b0);
        tick();
        tick();
        idle();
        chk("wrap", sb_if.stall_cycles, 32'd1);
        rst = 1'b1;
        #1;
        chk("wrap_rst", sb_if.stall_cycles, 32'd0);
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
